// File: rtl/gtx_frame_pkg.sv
// Shared framing definitions for the GTX LocalLink TX framer and the matching RX deframer.
// Holds the state encoding, the header layout and the running checksum helper.
package gtx_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] seq;
  } frame_hdr_t;

  function automatic logic [15:0] make_hdr(input logic [7:0] sync, input logic [7:0] seq);
    frame_hdr_t hdr;
    hdr.sync = sync;
    hdr.seq  = seq;
    return hdr;
  endfunction

  // Carries out of bit 15 are discarded on both ends of the link.
  function automatic logic [15:0] chk_add(input logic [15:0] sum, input logic [15:0] word);
    return sum + word;
  endfunction

endpackage

// File: rtl/gtx_tx_framer_if.sv
// Upstream payload stream (valid/ready) and LocalLink TX bus toward the Aurora GTX wrapper.
// master drives the forward signals, slave returns the ready.
interface gtx_pkt_if;
  logic [15:0] pkt_data;
  logic        pkt_sop;
  logic        pkt_valid;
  logic        pkt_ready;

  modport master (output pkt_data, output pkt_sop, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, input pkt_sop, input pkt_valid, output pkt_ready);
endinterface

interface gtx_ll_if;
  logic [15:0] gtx_tx_data;
  logic        gtx_tx_sof_n;
  logic        gtx_tx_eof_n;
  logic        gtx_tx_src_rdy_n;
  logic        gtx_tx_dst_rdy_n;

  modport master (output gtx_tx_data, output gtx_tx_sof_n, output gtx_tx_eof_n,
                  output gtx_tx_src_rdy_n, input gtx_tx_dst_rdy_n);
  modport slave  (input gtx_tx_data, input gtx_tx_sof_n, input gtx_tx_eof_n,
                  input gtx_tx_src_rdy_n, output gtx_tx_dst_rdy_n);
endinterface

// File: rtl/gtx_tx_framer.sv
// LocalLink TX framer: wraps PKT_WORDS payload words in a {SYNC_BYTE, seq} header and a
// 16-bit additive checksum, through a one-deep registered output stage.
//
// state   | meaning
// IDLE    | hunt for sop; non-sop words are dropped, output register empty
// HDR     | header in output register, waiting for its transfer
// PAYLOAD | forwarding payload words, accumulating checksum
// CHK     | checksum word (eof) loaded or pending, waiting for its transfer
module gtx_tx_framer
  import gtx_frame_pkg::*;
#(
  parameter int unsigned PKT_WORDS = 94,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        clk_gtp,
  input  logic        rst_gtp,
  input  logic        channel_up,
  gtx_pkt_if.slave    pkt,
  gtx_ll_if.master    ll,
  output logic        frame_abort,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned      IDX_W    = $clog2(PKT_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_WORDS - 1);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_HDR     = ST_HDR;
  localparam logic [1:0] S_PAYLOAD = ST_PAYLOAD;
  localparam logic [1:0] S_CHK     = ST_CHK;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [15:0]      sum;
  logic [7:0]       seq;

  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] out_data;

  logic xfer;
  logic load_ok;
  logic ready_c;
  logic accept;

  assign xfer    = out_valid & ~ll.gtx_tx_dst_rdy_n;
  assign load_ok = ~out_valid | xfer;

  // HDR takes the first payload word in the header's transfer cycle so the
  // frame streams at one word per clock when the link is not stalling.
  always_comb begin
    ready_c = 1'b0;
    case (state)
      S_IDLE:    ready_c = channel_up & ~(pkt.pkt_valid & pkt.pkt_sop);
      S_HDR:     ready_c = channel_up & xfer;
      S_PAYLOAD: ready_c = channel_up & load_ok;
      default:   ready_c = 1'b0;
    endcase
  end

  assign accept        = pkt.pkt_valid & ready_c;
  assign pkt.pkt_ready = ready_c & ~rst_gtp;

  assign ll.gtx_tx_data      = out_data;
  assign ll.gtx_tx_sof_n     = ~out_sof;
  assign ll.gtx_tx_eof_n     = ~out_eof;
  assign ll.gtx_tx_src_rdy_n = ~out_valid;

  always_ff @(posedge clk_gtp or posedge rst_gtp) begin
    if (rst_gtp) begin
      state       <= S_IDLE;
      idx         <= '0;
      sum         <= '0;
      seq         <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_data    <= '0;
      frame_abort <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
   end else begin
      frame_abort <= 1'b0;
      if (state != S_IDLE && !channel_up) begin
        out_valid   <= 1'b0;
        out_sof     <= 1'b0;
        out_eof     <= 1'b0;
        out_data    <= '0;
        frame_abort <= 1'b1;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (channel_up && pkt.pkt_valid && pkt.pkt_sop) begin
              out_valid <= 1'b1;
              out_sof   <= 1'b1;
              out_eof   <= 1'b0;
              out_data  <= make_hdr(SYNC_BYTE, seq);
              state     <= S_HDR;
            end
          end
          S_HDR: begin
            if (xfer) begin
              out_sof <= 1'b0;
              state   <= S_PAYLOAD;
              if (accept) begin
                out_data <= pkt.pkt_data;
                sum      <= chk_add(16'h0000, pkt.pkt_data);
                idx      <= IDX_W'(1);
              end else begin
                out_valid <= 1'b0;
                sum       <= '0;
                idx       <= '0;
              end
            end
          end
          S_PAYLOAD: begin
            if (accept) begin
              out_valid <= 1'b1;
              out_data  <= pkt.pkt_data;
              sum       <= chk_add(sum, pkt.pkt_data);
              idx       <= idx + IDX_W'(1);
              if (idx == IDX_LAST) state <= S_CHK;
            end else if (xfer) begin
              out_valid <= 1'b0;
            end
          end
          default: begin
            // out_eof marks that the checksum already sits in the output register.
            if (out_eof) begin
              if (xfer) begin
                out_valid <= 1'b0;
                out_eof   <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
                seq       <= seq + 8'd1;
                state     <= S_IDLE;
              end
            end else if (load_ok) begin
              out_valid <= 1'b1;
              out_eof   <= 1'b1;
              out_data  <= sum;
            end
          end
        endcase
      end
    end
  end

endmodule
